serial_sample_rx: RTL and testbench

SERIAL_SAMPLE_RX -- requirements
Module: serial_sample_rx

---
 rtl/serial_sample_rx.sv | 149 ++++++++++++++
 tb/tb_serial_sample_rx.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sample_rx.sv
// serial_sample_rx: strobe-sampled serial frame receiver.
// A frame is a start bit (0), NUM_BITS data bits and a stop bit (1). One bit
// is taken on each clk edge where shift_enable is high. Good words go to a
// single-entry valid/ready output register; a frame that completes while the
// register is still full is dropped and flagged on overrun.
//
// Ports:
//   clk            clock, rising edge
//   n_rst          asynchronous active-low reset
//   shift_enable   bit-period strobe
//   serial_in      serial line, idle high
//   data_ready     consumer accept
//   parallel_out   last good received word (registered)
//   data_valid     parallel_out holds an unconsumed word
//   framing_error  one-cycle pulse when a stop bit samples 0
//   overrun        sticky: a good word was dropped, cleared by handshake
module serial_sample_rx #(
  parameter int unsigned NUM_BITS  = 16,
  parameter bit          SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                data_ready,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic                data_valid,
  output logic                framing_error,
  output logic                overrun
);

  // Wide enough to hold NUM_BITS itself, so the counter never wraps in a frame.
  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] r_parallel_out;
  logic                r_data_valid;
  logic                r_framing_error;
  logic                r_overrun;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_bit_cnt_nxt;
  logic [NUM_BITS-1:0] w_shift_nxt;
  logic [NUM_BITS-1:0] w_parallel_out_nxt;
  logic                w_data_valid_nxt;
  logic                w_framing_error_nxt;
  logic                w_overrun_nxt;

  logic [NUM_BITS-1:0] w_shifted;
  logic                w_accept;
  logic                w_last_bit;

  // Shift register with the incoming bit appended at the bit-order end.
  if (SHIFT_MSB) begin : g_shift_left
    assign w_shifted = {r_shift[NUM_BITS-2:0], serial_in};
  end else begin : g_shift_right
    assign w_shifted = {serial_in, r_shift[NUM_BITS-1:1]};
  end

  assign w_accept   = r_data_valid & data_ready;
  assign w_last_bit = (r_bit_cnt == CNT_W'(NUM_BITS - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= IDLE;
      r_bit_cnt       <= '0;
      r_shift         <= '1;
      r_parallel_out  <= '0;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_shift         <= w_shift_nxt;
      r_parallel_out  <= w_parallel_out_nxt;
      r_data_valid    <= w_data_valid_nxt;
      r_framing_error <= w_framing_error_nxt;
      r_overrun       <= w_overrun_nxt;
    end
  end

  // Next-state, datapath and output-register update.
  always_comb begin
    w_state_nxt         = r_state;
    w_bit_cnt_nxt       = r_bit_cnt;
    w_shift_nxt         = r_shift;
    w_parallel_out_nxt  = r_parallel_out;
    w_data_valid_nxt    = r_data_valid;
    w_framing_error_nxt = 1'b0;
    w_overrun_nxt       = r_overrun;

    // Consumer handshake; a same-edge load below overrides data_valid.
    if (w_accept) begin
      w_data_valid_nxt = 1'b0;
      w_overrun_nxt    = 1'b0;
    end

    if (shift_enable) begin
      case (r_state)
        IDLE: begin
          if (!serial_in) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
          end
        end
        DATA: begin
          w_shift_nxt   = w_shifted;
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (w_last_bit) begin
            w_state_nxt = STOP;
          end
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (serial_in) begin
            // Load if the output slot is empty or being emptied this edge.
            if (!r_data_valid || data_ready) begin
              w_parallel_out_nxt = r_shift;
              w_data_valid_nxt   = 1'b1;
            end else begin
              w_overrun_nxt = 1'b1;
            end
          end else begin
            w_framing_error_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign parallel_out  = r_parallel_out;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_serial_sample_rx.sv
// Bench for serial_sample_rx: two instances (MSB-first and LSB-first,
// NUM_BITS=8) share one serial line; a frame-level model predicts outputs.
module tb_serial_sample_rx;

  logic       clk;
  logic       n_rst;
  logic       shift_enable;
  logic       serial_in;
  logic       data_ready;
  logic [7:0] po_m, po_l;
  logic       dv_m, dv_l, fe_m, fe_l, ov_m, ov_l;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model of the output side.
  logic [7:0] m_out_m, m_out_l;
  logic       m_valid, m_fe, m_ovr;

  typedef struct {
    logic       se;
    logic       sin;
    int         ev;   // 0 none, 1 good stop, 2 bad stop
    logic [7:0] wm;
    logic [7:0] wl;
  } step_t;
  step_t q[$];

  serial_sample_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u_msb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .data_ready(data_ready), .parallel_out(po_m), .data_valid(dv_m),
    .framing_error(fe_m), .overrun(ov_m));

  serial_sample_rx #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_lsb (
    .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .data_ready(data_ready), .parallel_out(po_l), .data_valid(dv_l),
    .framing_error(fe_l), .overrun(ov_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transmission order for a word sent MSB first.
  function automatic logic [7:0] msb_seq(input logic [7:0] w);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = w[7-i];
    return s;
  endfunction

  function automatic void model_reset();
    m_out_m = 8'h00; m_out_l = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
  endfunction

  // One clock: drive, take the edge, update the model, settle 1 time unit.
  task automatic cycle(input logic se, input logic sin, input int ev,
                       input logic [7:0] wm, input logic [7:0] wl);
    logic acc;
    shift_enable = se;
    serial_in    = sin;
    @(posedge clk);
    if (n_rst) begin
      acc  = m_valid && data_ready;
      m_fe = (ev == 2);
      if (ev == 1) begin
        if (!m_valid || data_ready) begin
          m_out_m = wm; m_out_l = wl; m_valid = 1'b1;
          if (acc) m_ovr = 1'b0;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (acc) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
    end
    #1;
  endtask

  task automatic add_gap(input int gap);
    step_t s;
    for (int g = 0; g < gap; g++) begin
      s.se = 1'b0; s.sin = 1'($urandom); s.ev = 0; s.wm = 8'h00; s.wl = 8'h00;
      q.push_back(s);
    end
  endtask

  // Queue one frame; ends on the stop-bit strobe (no trailing gap).
  task automatic build_frame(input logic [7:0] seq, input logic stop_ok, input int gap);
    step_t s;
    int wm, wl;
    wm = 0; wl = 0;
    for (int i = 0; i < 8; i++) begin
      wm = wm + (int'(seq[i]) << (7 - i));
      wl = wl + (int'(seq[i]) << i);
    end
    s.se = 1'b1; s.sin = 1'b0; s.ev = 0; s.wm = 8'h00; s.wl = 8'h00;
    q.push_back(s);
    add_gap(gap);
    for (int i = 0; i < 8; i++) begin
      s.se = 1'b1; s.sin = seq[i]; s.ev = 0; s.wm = 8'h00; s.wl = 8'h00;
      q.push_back(s);
      add_gap(gap);
    end
    s.se = 1'b1; s.sin = stop_ok; s.ev = stop_ok ? 1 : 2;
    s.wm = 8'(wm); s.wl = 8'(wl);
    q.push_back(s);
  endtask

  task automatic run_queue();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      cycle(s.se, s.sin, s.ev, s.wm, s.wl);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; shift_enable = 1'b0; serial_in = 1'b1; data_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({po_m, po_l, dv_m, dv_l, fe_m, fe_l, ov_m, ov_l} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_state: got po_m=%h po_l=%h dv=%b%b fe=%b%b ov=%b%b required all 0",
               po_m, po_l, dv_m, dv_l, fe_m, fe_l, ov_m, ov_l);
    end
    n_rst = 1'b1;
    repeat (2) cycle(1'b1, 1'b1, 0, 8'h00, 8'h00);
    n_cmp++;
    if (dv_m !== 1'b0 || dv_l !== 1'b0) begin
      n_err++; $display("FAIL idle_strobes: dv=%b%b required 00", dv_m, dv_l);
    end
  endtask

  task automatic test_vectors();
    data_ready = 1'b0;
    build_frame(8'h4D, 1'b1, 3);  // data bits 1,0,1,1,0,0,1,0
    run_queue();
    n_cmp++;
    if (po_m !== 8'hB2) begin n_err++; $display("FAIL msb_word: got %h required b2", po_m); end
    n_cmp++;
    if (po_l !== 8'h4D) begin n_err++; $display("FAIL lsb_word: got %h required 4d", po_l); end
    n_cmp++;
    if (dv_m !== 1'b1 || dv_l !== 1'b1 || fe_m !== 1'b0 || fe_l !== 1'b0) begin
      n_err++; $display("FAIL vec_flags: dv=%b%b fe=%b%b required dv=11 fe=00", dv_m, dv_l, fe_m, fe_l);
    end
    data_ready = 1'b1;
    cycle(1'b0, 1'b1, 0, 8'h00, 8'h00);
    data_ready = 1'b0;
    n_cmp++;
    if (dv_m !== 1'b0 || po_m !== 8'hB2 || po_l !== 8'h4D) begin
      n_err++; $display("FAIL vec_consume: dv=%b po_m=%h po_l=%h required dv=0 b2 4d", dv_m, po_m, po_l);
    end
  endtask

  task automatic test_framing();
    build_frame(8'($urandom), 1'b0, 3);
    run_queue();
    n_cmp++;
    if (fe_m !== 1'b1 || fe_l !== 1'b1 || dv_m !== 1'b0 || dv_l !== 1'b0) begin
      n_err++; $display("FAIL fe_pulse: fe=%b%b dv=%b%b required fe=11 dv=00", fe_m, fe_l, dv_m, dv_l);
    end
    cycle(1'b0, 1'b0, 0, 8'h00, 8'h00);
    n_cmp++;
    if (fe_m !== 1'b0 || fe_l !== 1'b0) begin
      n_err++; $display("FAIL fe_width: fe=%b%b required 00", fe_m, fe_l);
    end
    build_frame(8'hFF, 1'b1, 3);
    run_queue();
    n_cmp++;
    if (po_m !== 8'hFF || po_l !== 8'hFF || dv_m !== 1'b1 || ov_m !== 1'b0) begin
      n_err++; $display("FAIL after_fe: po=%h/%h dv=%b ov=%b required ff/ff 1 0", po_m, po_l, dv_m, ov_m);
    end
    data_ready = 1'b1;
    cycle(1'b0, 1'b1, 0, 8'h00, 8'h00);
    data_ready = 1'b0;
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    build_frame(msb_seq(8'h12), 1'b1, 3);
    build_frame(msb_seq(8'h34), 1'b1, 3);
    run_queue();
    n_cmp++;
    if (po_m !== 8'h12 || po_l !== 8'h48) begin
      n_err++; $display("FAIL ovr_hold: po=%h/%h required 12/48", po_m, po_l);
    end
    n_cmp++;
    if (ov_m !== 1'b1 || ov_l !== 1'b1 || dv_m !== 1'b1) begin
      n_err++; $display("FAIL ovr_set: ov=%b%b dv=%b required 11 1", ov_m, ov_l, dv_m);
    end
    data_ready = 1'b1;
    cycle(1'b0, 1'b1, 0, 8'h00, 8'h00);
    data_ready = 1'b0;
    n_cmp++;
    if (ov_m !== 1'b0 || ov_l !== 1'b0 || dv_m !== 1'b0 || dv_l !== 1'b0) begin
      n_err++; $display("FAIL ovr_clear: ov=%b%b dv=%b%b required 00 00", ov_m, ov_l, dv_m, dv_l);
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    data_ready = 1'b1;
    build_frame(msb_seq(8'hA5), 1'b1, 3);
    run_queue();
    n_cmp++;
    if (po_m !== 8'hA5 || dv_m !== 1'b1 || ov_m !== 1'b0) begin
      n_err++; $display("FAIL b2b_first: po=%h dv=%b ov=%b required a5 1 0", po_m, dv_m, ov_m);
    end
    build_frame(msb_seq(8'h5A), 1'b1, 3);
    s = q.pop_front();
    cycle(s.se, s.sin, s.ev, s.wm, s.wl);
    n_cmp++;
    if (dv_m !== 1'b0 || dv_l !== 1'b0) begin
      n_err++; $display("FAIL b2b_one_cycle: dv=%b%b required 00", dv_m, dv_l);
    end
    run_queue();
    n_cmp++;
    if (po_m !== 8'h5A || po_l !== 8'h5A || dv_m !== 1'b1 || ov_m !== 1'b0 || ov_l !== 1'b0) begin
      n_err++; $display("FAIL b2b_second: po=%h/%h dv=%b ov=%b%b required 5a/5a 1 00",
                        po_m, po_l, dv_m, ov_m, ov_l);
    end
    cycle(1'b0, 1'b1, 0, 8'h00, 8'h00);
    data_ready = 1'b0;
    n_cmp++;
    if (dv_m !== 1'b0) begin n_err++; $display("FAIL b2b_drain: dv=%b required 0", dv_m); end
  endtask

  task automatic test_mid_reset();
    step_t s;
    data_ready = 1'b0;
    build_frame(msb_seq(8'h77), 1'b1, 3);
    run_queue();
    // Start bit plus data bits 0..3, then reset.
    cycle(1'b1, 1'b0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      repeat (3) cycle(1'b0, 1'b1, 0, 8'h00, 8'h00);
      cycle(1'b1, 1'($urandom), 0, 8'h00, 8'h00);
    end
    n_rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({po_m, po_l, dv_m, dv_l, fe_m, fe_l, ov_m, ov_l} !== 22'd0) begin
      n_err++; $display("FAIL async_reset: po=%h/%h dv=%b%b required 00/00 00", po_m, po_l, dv_m, dv_l);
    end
    repeat (2) cycle(1'b1, 1'b0, 0, 8'h00, 8'h00);
    n_rst = 1'b1;
    build_frame(msb_seq(8'hC3), 1'b1, 3);
    while (q.size() > 1) begin
      s = q.pop_front();
      cycle(s.se, s.sin, s.ev, s.wm, s.wl);
      n_cmp++;
      if (dv_m !== 1'b0 || fe_m !== 1'b0 || ov_m !== 1'b0) begin
        n_err++; $display("FAIL rst_quiet: dv=%b fe=%b ov=%b required 000", dv_m, fe_m, ov_m);
      end
    end
    run_queue();
    n_cmp++;
    if (po_m !== 8'hC3 || po_l !== 8'hC3 || dv_m !== 1'b1 || fe_m !== 1'b0 || ov_m !== 1'b0) begin
      n_err++; $display("FAIL rst_then_c3: po=%h/%h dv=%b fe=%b ov=%b required c3/c3 1 0 0",
                        po_m, po_l, dv_m, fe_m, ov_m);
    end
    data_ready = 1'b1;
    cycle(1'b0, 1'b1, 0, 8'h00, 8'h00);
    data_ready = 1'b0;
  endtask

  task automatic test_random();
    step_t s;
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        s.se = 1'($urandom); s.sin = s.se ? 1'b1 : 1'($urandom);
        s.ev = 0; s.wm = 8'h00; s.wl = 8'h00;
        q.push_back(s);
      end
      build_frame(8'($urandom), ($urandom_range(0, 4) != 0), int'($urandom_range(0, 2)));
      while (q.size() > 0) begin
        s = q.pop_front();
        data_ready = 1'($urandom);
        cycle(s.se, s.sin, s.ev, s.wm, s.wl);
        n_cmp++;
        if (dv_m !== m_valid || dv_l !== m_valid) begin
          n_err++; $display("FAIL rnd_valid: frame %0d got %b%b required %b", f, dv_m, dv_l, m_valid);
        end
        n_cmp++;
        if (po_m !== m_out_m || po_l !== m_out_l) begin
          n_err++; $display("FAIL rnd_word: frame %0d got %h/%h required %h/%h",
                            f, po_m, po_l, m_out_m, m_out_l);
        end
        n_cmp++;
        if (fe_m !== m_fe || fe_l !== m_fe) begin
          n_err++; $display("FAIL rnd_fe: frame %0d got %b%b required %b", f, fe_m, fe_l, m_fe);
        end
        n_cmp++;
        if (ov_m !== m_ovr || ov_l !== m_ovr) begin
          n_err++; $display("FAIL rnd_ovr: frame %0d got %b%b required %b", f, ov_m, ov_l, m_ovr);
        end
      end
    end
    data_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
